// File: rtl/gameover_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gameover_pkg
// Shared definitions for the game-over arbiter:
//   - state_t       : 3-bit round-state encoding, also driven on gameover_state
//   - DEF_*         : default parameter values for the arbiter and its players
//   - max_int()     : helper used to size the shared dwell counter
// -----------------------------------------------------------------------------
package gameover_pkg;

    typedef enum logic [2:0] {
        ST_NONE     = 3'd0,  // round in progress, hits are evaluated
        ST_GAMEOVER = 3'd1,  // round decided, result latched
        ST_WIN      = 3'd2,  // winner banner
        ST_DRAW     = 3'd3,  // draw banner
        ST_FINISH   = 3'd4   // waiting for a restart request
    } state_t;

    localparam int DEF_NUM_PLAYERS = 2;
    localparam int DEF_COR_BITS    = 8;
    localparam int DEF_LIVES       = 1;
    localparam int DEF_INVULN_CYC  = 30;
    localparam int DEF_HOLD_CYC    = 60;
    localparam int DEF_BANNER_CYC  = 90;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gameover_arbiter_if.sv
// -----------------------------------------------------------------------------
// gameover_arbiter_if
// Signal bundle for one game-over arbiter instance. There is no valid/ready
// handshake on this block: every input is a level sampled on each rising clk
// edge, and every output is a registered level (o_hit is a one-cycle pulse).
//   master : drives explode/player_cor/restart, observes the results
//   slave  : the arbiter side of the same signals
// -----------------------------------------------------------------------------
interface gameover_arbiter_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int COR_BITS    = 8,
    parameter int CNT_W       = 7
);
    logic [2**COR_BITS-1:0]        explode;
    logic [NUM_PLAYERS*COR_BITS-1:0] player_cor;
    logic                          restart;
    logic [2:0]                    state;
    logic [1:0]                    winner;
    logic                          draw;
    logic [NUM_PLAYERS*3-1:0]      lives;
    logic [NUM_PLAYERS-1:0]        hit;
    logic [CNT_W-1:0]              count;

    modport master (
        output explode, player_cor, restart,
        input  state, winner, draw, lives, hit, count
    );

    modport slave (
        input  explode, player_cor, restart,
        output state, winner, draw, lives, hit, count
    );
endinterface

// File: rtl/gameover_arbiter_player_life.sv
// -----------------------------------------------------------------------------
// player_life
// Lives counter, invulnerability timer and hit detection for one player.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   i_reload        : new round, reload lives and clear timers (like reset)
//   i_eval          : 1 while the round is in progress (hits allowed)
//   i_explode       : per-cell explosion flags
//   i_cor           : this player's cell coordinate
//   o_lives         : registered remaining lives
//   o_lives_next    : lives after this cycle's hit, used for the alive count
//   o_hit           : one-cycle pulse the cycle after a life is lost
// -----------------------------------------------------------------------------
module player_life #(
    parameter int COR_BITS   = 8,
    parameter int LIVES      = 1,
    parameter int INVULN_CYC = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_reload,
    input  logic                   i_eval,
    input  logic [2**COR_BITS-1:0] i_explode,
    input  logic [COR_BITS-1:0]    i_cor,
    output logic [2:0]             o_lives,
    output logic [2:0]             o_lives_next,
    output logic                   o_hit
);
    localparam int IW = (INVULN_CYC > 0) ? $clog2(INVULN_CYC + 1) : 1;

    logic [2:0]    lives_q, lives_d;
    logic [IW-1:0] invuln_q, invuln_d;
    logic          hit_q, hit_d;

    always_comb begin
        hit_d   = i_eval && (lives_q != 3'd0) && (invuln_q == '0) && i_explode[i_cor];
        lives_d = hit_d ? (lives_q - 3'd1) : lives_q;
        // A fatal hit leaves the timer idle; a surviving hit restarts it.
        if (hit_d && (lives_d != 3'd0)) begin
            invuln_d = IW'(INVULN_CYC);
        end else if (invuln_q != '0) begin
            invuln_d = invuln_q - IW'(1);
        end else begin
            invuln_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_reload) begin
            lives_q  <= 3'(LIVES);
            invuln_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            lives_q  <= lives_d;
            invuln_q <= invuln_d;
            hit_q    <= hit_d;
        end
    end

    assign o_lives      = lives_q;
    assign o_lives_next = lives_d;
    assign o_hit        = hit_q;
endmodule

// File: rtl/gameover_arbiter.sv
// -----------------------------------------------------------------------------
// gameover_arbiter
// Tracks player lives during a round, decides win/draw when at most one
// player survives, and sequences GAMEOVER -> WIN/DRAW -> FINISH banners.
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   i_explode        : per-cell explosion flags
//   i_player_cor     : player k coordinate at [k*COR_BITS +: COR_BITS]
//   i_restart        : new-round request, honoured only in FINISH
//   gameover_state   : current state_t encoding
//   o_winner         : lowest-index survivor, latched on entry to GAMEOVER
//   o_draw           : 1 when nobody survived the round
//   o_lives          : player k lives at [k*3 +: 3]
//   o_hit            : per-player life-lost pulse
//   o_count          : dwell counter, exposed for observation
// -----------------------------------------------------------------------------
module gameover_arbiter
    import gameover_pkg::*;
#(
    parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int COR_BITS    = DEF_COR_BITS,
    parameter int LIVES       = DEF_LIVES,
    parameter int INVULN_CYC  = DEF_INVULN_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int BANNER_CYC  = DEF_BANNER_CYC,
    parameter int CNT_W       = (max_int(HOLD_CYC, BANNER_CYC) > 0) ?
                                $clog2(max_int(HOLD_CYC, BANNER_CYC) + 1) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2**COR_BITS-1:0]          i_explode,
    input  logic [NUM_PLAYERS*COR_BITS-1:0] i_player_cor,
    input  logic                            i_restart,
    output logic [2:0]                      gameover_state,
    output logic [1:0]                      o_winner,
    output logic                            o_draw,
    output logic [NUM_PLAYERS*3-1:0]        o_lives,
    output logic [NUM_PLAYERS-1:0]          o_hit,
    output logic [CNT_W-1:0]                o_count
);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       winner_q;
    logic             draw_q;

    logic [2:0] lives_next [NUM_PLAYERS];
    logic [2:0] alive_cnt;
    logic [1:0] win_idx;
    logic       eval;
    logic       reload;

    assign eval   = (state_q == ST_NONE);
    assign reload = (state_q == ST_FINISH) && i_restart;

    for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_player
        player_life #(
            .COR_BITS  (COR_BITS),
            .LIVES     (LIVES),
            .INVULN_CYC(INVULN_CYC)
        ) u_player (
            .clk         (clk),
            .reset       (reset),
            .i_reload    (reload),
            .i_eval      (eval),
            .i_explode   (i_explode),
            .i_cor       (i_player_cor[k*COR_BITS +: COR_BITS]),
            .o_lives     (o_lives[k*3 +: 3]),
            .o_lives_next(lives_next[k]),
            .o_hit       (o_hit[k])
        );
    end

    // Alive count and winner use post-hit lives so a killing blow in this
    // cycle ends the round at the same edge. Scanning downward leaves the
    // lowest-index survivor in win_idx.
    always_comb begin
        alive_cnt = 3'd0;
        win_idx   = 2'd0;
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            if (lives_next[k] != 3'd0) begin
                alive_cnt = alive_cnt + 3'd1;
                win_idx   = 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_NONE;
            cnt_q    <= '0;
            winner_q <= 2'd0;
            draw_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_NONE: begin
                    cnt_q <= '0;
                    if (alive_cnt <= 3'd1) begin
                        state_q  <= ST_GAMEOVER;
                        winner_q <= win_idx;
                        draw_q   <= (alive_cnt == 3'd0);
                    end
                end
                ST_GAMEOVER: begin
                    if (cnt_q == CNT_W'(HOLD_CYC)) begin
                        state_q <= draw_q ? ST_DRAW : ST_WIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WIN, ST_DRAW: begin
                    if (cnt_q == CNT_W'(BANNER_CYC)) begin
                        state_q <= ST_FINISH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    cnt_q <= '0;
                    if (i_restart) begin
                        state_q  <= ST_NONE;
                        winner_q <= 2'd0;
                        draw_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_NONE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gameover_state = state_q;
    assign o_winner       = winner_q;
    assign o_draw         = draw_q;
    assign o_count        = cnt_q;
endmodule
